// File: rtl/mmio_pkg.sv
// Shared address map, region encoding and STATUS bit layout for mmio_responder.
package mmio_pkg;

    localparam int unsigned RAM_BASE           = 32'h00;
    localparam int unsigned GPIO_OUT_ADDR      = 32'h80;
    localparam int unsigned GPIO_IN_ADDR       = 32'h84;
    localparam int unsigned TIMER_COUNT_ADDR   = 32'h88;
    localparam int unsigned TIMER_COMPARE_ADDR = 32'h8C;
    localparam int unsigned STATUS_ADDR        = 32'h90;

    localparam int TIMER_WIDTH      = 32;
    localparam int STATUS_MATCH_BIT = 0;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_GPIO_OUT,
        REGION_GPIO_IN,
        REGION_TIMER_COUNT,
        REGION_TIMER_COMPARE,
        REGION_STATUS,
        REGION_NONE
    } region_t;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear on reset.
module input_synchronizer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_p0 <= '0;
            synced   <= '0;
        end else begin
            stage_p0 <= raw;
            synced   <= stage_p0;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Single-cycle MMIO responder: scratch RAM, GPIO out/in and an optional timer.
// The timer, compare register, STATUS and timer_irq exist only when MMIO_TIMER_EN is defined.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int RAM_WORDS     = 16,
    parameter int GPIO_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     write_enable,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data,
    input  logic [GPIO_WIDTH-1:0]    gpio_in,
    output logic [GPIO_WIDTH-1:0]    gpio_out,
    output logic                     timer_irq
);

    localparam int INDEX_WIDTH = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int RAM_BYTES   = 4 * RAM_WORDS;

    region_t                   region;
    logic [ADDRESS_WIDTH-3:0]  word_address;
    logic [INDEX_WIDTH-1:0]    ram_index;
    logic [GPIO_WIDTH-1:0]     gpio_sync;
    logic [DATA_WIDTH-1:0]     ram [RAM_WORDS];

    assign word_address = address[ADDRESS_WIDTH-1:2];
    assign ram_index    = address[INDEX_WIDTH+1:2];

    // Register offsets are compared on word granularity so byte lanes alias.
    always_comb begin
        region = REGION_NONE;
        if (address < ADDRESS_WIDTH'(RAM_BYTES))
            region = REGION_RAM;
        else if (word_address == (ADDRESS_WIDTH-2)'(GPIO_OUT_ADDR >> 2))
            region = REGION_GPIO_OUT;
        else if (word_address == (ADDRESS_WIDTH-2)'(GPIO_IN_ADDR >> 2))
            region = REGION_GPIO_IN;
`ifdef MMIO_TIMER_EN
        else if (word_address == (ADDRESS_WIDTH-2)'(TIMER_COUNT_ADDR >> 2))
            region = REGION_TIMER_COUNT;
        else if (word_address == (ADDRESS_WIDTH-2)'(TIMER_COMPARE_ADDR >> 2))
            region = REGION_TIMER_COMPARE;
        else if (word_address == (ADDRESS_WIDTH-2)'(STATUS_ADDR >> 2))
            region = REGION_STATUS;
`endif
    end

    always_ff @(posedge clock) begin
        if (write_enable && region == REGION_RAM)
            ram[ram_index] <= write_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            gpio_out <= '0;
        else if (write_enable && region == REGION_GPIO_OUT)
            gpio_out <= write_data[GPIO_WIDTH-1:0];
    end

    input_synchronizer #(
        .WIDTH(GPIO_WIDTH)
    ) u_gpio_sync (
        .clock  (clock),
        .reset  (reset),
        .raw    (gpio_in),
        .synced (gpio_sync)
    );

`ifdef MMIO_TIMER_EN
    logic [TIMER_WIDTH-1:0] timer_count;
    logic [TIMER_WIDTH-1:0] timer_compare;
    logic                   match_flag;

    // A match on the same edge as a clear keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_count   <= '0;
            timer_compare <= '1;
            match_flag    <= 1'b0;
        end else begin
            if (write_enable && region == REGION_TIMER_COUNT)
                timer_count <= write_data[TIMER_WIDTH-1:0];
            else
                timer_count <= timer_count + 1'b1;

            if (write_enable && region == REGION_TIMER_COMPARE)
                timer_compare <= write_data[TIMER_WIDTH-1:0];

            if (timer_count == timer_compare)
                match_flag <= 1'b1;
            else if (write_enable && region == REGION_STATUS && write_data[STATUS_MATCH_BIT])
                match_flag <= 1'b0;
        end
    end

    assign timer_irq = match_flag;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        case (region)
            REGION_RAM:           read_data = ram[ram_index];
            REGION_GPIO_OUT:      read_data = DATA_WIDTH'(gpio_out);
            REGION_GPIO_IN:       read_data = DATA_WIDTH'(gpio_sync);
`ifdef MMIO_TIMER_EN
            REGION_TIMER_COUNT:   read_data = DATA_WIDTH'(timer_count);
            REGION_TIMER_COMPARE: read_data = DATA_WIDTH'(timer_compare);
            REGION_STATUS:        read_data[STATUS_MATCH_BIT] = match_flag;
`endif
            default:              read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: vector table plus timer/GPIO/reset sequences.
module tb_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_data    (read_data),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .timer_irq    (timer_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic        chk;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[16];

`ifdef MMIO_TIMER_EN
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] COMPARE_RESET = 32'h0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, queue the expected load, compare once settled.
    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input logic chk, input logic [31:0] exp, input string name);
        @(negedge clock);
        write_enable = we;
        address      = addr;
        write_data   = wd;
        if (chk) exp_q.push_back(exp);
        #1;
        if (chk) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                check(name, read_data, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'h04, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 8'h08, 32'h1234_5678, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 8'h04, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 8'h08, 32'h0,         32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 8'h05, 32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b1, 8'h04, 32'h1111_1111, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 8'h04, 32'h0,         32'h1111_1111};
        vecs[7]  = '{1'b1, 1'b0, 8'h80, 32'h0000_01A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 8'h80, 32'h0,         32'h0000_00A5};
        vecs[9]  = '{1'b1, 1'b0, 8'hF0, 32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 8'hF0, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 1'b1, 8'h80, 32'h0,         32'h0000_00A5};
        vecs[12] = '{1'b0, 1'b1, 8'h40, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 1'b1, 8'h84, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 1'b0, 8'h44, 32'hCAFE_F00D, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 8'h04, 32'h0,         32'h1111_1111};

        reset        = 1'b1;
        address      = 8'h00;
        write_enable = 1'b0;
        write_data   = 32'h0;
        gpio_in      = 8'h00;

        // Reset state
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'h0, "reset count");
        bus(1'b0, 8'h8C, 32'h0, 1'b1, COMPARE_RESET, "reset compare");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h0, "reset status");
        check("reset gpio_out", {24'h0, gpio_out}, 32'h0);
        check("reset irq", {31'h0, timer_irq}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
                $sformatf("vec%0d addr %h", i, vecs[i].addr));
        check("gpio_out after write", {24'h0, gpio_out}, 32'h0000_00A5);

        // GPIO input synchronizer latency
        bus(1'b0, 8'h84, 32'h0, 1'b1, 32'h0, "gpio_in idle");
        gpio_in = 8'h3C;
        #1;
        check("gpio_in same cycle", read_data, 32'h0);
        bus(1'b0, 8'h84, 32'h0, 1'b1, 32'h0, "gpio_in after 1 edge");
        bus(1'b0, 8'h84, 32'h0, 1'b1, 32'h0000_003C, "gpio_in after 2 edges");
        bus(1'b0, 8'h84, 32'h0, 1'b1, 32'h0000_003C, "gpio_in after 3 edges");

`ifdef MMIO_TIMER_EN
        bus(1'b1, 8'h88, 32'd5,  1'b0, 32'h0, "count write");
        bus(1'b1, 8'h8C, 32'd10, 1'b1, 32'hFFFF_FFFF, "compare old on write");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'd6, "count 6");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'd7, "count 7");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h0, "status at 8");
        bus(1'b0, 8'h8C, 32'h0, 1'b1, 32'd10, "compare readback");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h0, "status at 10");
        check("irq before match", {31'h0, timer_irq}, 32'h0);
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h1, "status after match");
        check("irq after match", {31'h0, timer_irq}, 32'h1);
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'd12, "count 12");
        bus(1'b1, 8'h90, 32'h0, 1'b0, 32'h0, "status write 0");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h1, "status kept by write 0");
        check("irq kept by write 0", {31'h0, timer_irq}, 32'h1);
        bus(1'b1, 8'h90, 32'h1, 1'b0, 32'h0, "status clear");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h0, "status cleared");
        check("irq cleared", {31'h0, timer_irq}, 32'h0);
        bus(1'b1, 8'h8C, 32'h0, 1'b0, 32'h0, "compare 0");
        bus(1'b1, 8'h88, 32'hFFFF_FFFE, 1'b0, 32'h0, "count near wrap");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'hFFFF_FFFE, "count FFFFFFFE");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'hFFFF_FFFF, "count FFFFFFFF");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'h0, "count wrapped");
        check("irq before wrap match", {31'h0, timer_irq}, 32'h0);
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h1, "status after wrap match");
        check("irq after wrap match", {31'h0, timer_irq}, 32'h1);
        bus(1'b1, 8'h88, 32'h0, 1'b0, 32'h0, "count 0 again");
        bus(1'b1, 8'h90, 32'h1, 1'b0, 32'h0, "clear with match");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h1, "set wins over clear");
`else
        bus(1'b1, 8'h88, 32'h1234, 1'b0, 32'h0, "count write ignored");
        bus(1'b1, 8'h8C, 32'h5,    1'b0, 32'h0, "compare write ignored");
        bus(1'b1, 8'h90, 32'h1,    1'b0, 32'h0, "status write ignored");
        bus(1'b0, 8'h88, 32'h0, 1'b1, 32'h0, "no timer count");
        bus(1'b0, 8'h8C, 32'h0, 1'b1, 32'h0, "no timer compare");
        bus(1'b0, 8'h90, 32'h0, 1'b1, 32'h0, "no timer status");
        check("no timer irq", {31'h0, timer_irq}, 32'h0);
`endif

        // Asynchronous reset in the middle of a cycle
        bus(1'b1, 8'h80, 32'h0000_00FF, 1'b0, 32'h0, "gpio FF");
        bus(1'b0, 8'h88, 32'h0, 1'b0, 32'h0, "idle");
        check("gpio_out FF", {24'h0, gpio_out}, 32'h0000_00FF);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset gpio_out", {24'h0, gpio_out}, 32'h0);
        check("mid reset irq", {31'h0, timer_irq}, 32'h0);
        check("mid reset count", read_data, 32'h0);
        address = 8'h8C;
        #1;
        check("mid reset compare", read_data, COMPARE_RESET);
        address = 8'h90;
        #1;
        check("mid reset status", read_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        bus(1'b0, 8'h08, 32'h0, 1'b1, 32'h1234_5678, "ram kept 0x08");
        bus(1'b0, 8'h04, 32'h0, 1'b1, 32'h1111_1111, "ram kept 0x04");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
